// File: rtl/sim_pkg.sv
// Shared types and constants for the rope simulation: scheduler state encoding,
// Q16.16 fixed-point constants and the index-width helper.
package sim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_VERLET     = 3'd1,
        ST_SOLVE_REQ  = 3'd2,
        ST_SOLVE_WAIT = 3'd3,
        ST_WRITE      = 3'd4,
        ST_PIN        = 3'd5,
        ST_DONE       = 3'd6
    } sched_state_e;

    localparam int FX_FRAC = 16;
    localparam logic signed [31:0] FX_ONE     = 32'sh0001_0000;
    localparam logic signed [31:0] FX_TWO     = 32'sh0002_0000;
    // 9.81 m/s^2 scaled to one 60 Hz frame squared, pointing down.
    localparam logic signed [31:0] FX_GRAVITY = -32'sh0000_00B3;

    // Index width for n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_iter_counter.sv
// Nested segment/iteration counter for the frame sequencer. idx walks the segments,
// iter counts relaxation passes; wrap_seg marks the final segment, last the final one overall.
module seg_iter_counter
    import sim_pkg::*;
#(
    parameter int NUM_SEGS   = 7,
    parameter int ITERATIONS = 4,
    parameter int IDX_W      = idx_width(NUM_SEGS + 1),
    parameter int ITER_W     = idx_width(ITERATIONS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_step,
    output logic [IDX_W-1:0]  o_idx,
    output logic [ITER_W-1:0] o_iter,
    output logic              o_wrap_seg,
    output logic              o_last
);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_SEGS - 1);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ITERATIONS - 1);

    logic [IDX_W-1:0]  r_idx;
    logic [ITER_W-1:0] r_iter;
    logic              w_wrap_seg;
    logic              w_last;

    assign w_wrap_seg = (r_idx == LAST_IDX);
    assign w_last     = w_wrap_seg && (r_iter == LAST_ITER);

    // At the very last step both counters hold; the sequencer leaves the loop.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_idx  <= '0;
            r_iter <= '0;
        end else if (i_step) begin
            if (!w_wrap_seg) begin
                r_idx <= r_idx + 1'b1;
            end else if (!w_last) begin
                r_idx  <= '0;
                r_iter <= r_iter + 1'b1;
            end
        end
    end

    assign o_idx      = r_idx;
    assign o_iter     = r_iter;
    assign o_wrap_seg = w_wrap_seg;
    assign o_last     = w_last;

endmodule

// File: rtl/verlet_scheduler.sv
// Rope frame sequencer: Verlet step, ITERATIONS relaxation passes through the shared solver,
// optional anchor pin. VERLET_SCHED_PIN_EN enables the PIN state and anchor_sel.
//
// state      | meaning
// IDLE       | waiting for frame_tick; idx/iter cleared
// VERLET     | integrate pulse to all nodes
// SOLVE_REQ  | solver_start for segment idx
// SOLVE_WAIT | holding for solver_done
// WRITE      | nodes idx and idx+1 latch corrected positions
// PIN        | node 0 reloaded from anchor (pin build only)
// DONE       | frame_done pulse
module verlet_scheduler
    import sim_pkg::*;
#(
    parameter int NUM_NODES  = 8,
    parameter int ITERATIONS = 4,
    parameter int IDX_W      = idx_width(NUM_NODES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    output logic                 verlet_state,
    output logic                 solver_start,
    output logic [IDX_W-1:0]     solver_idx,
    input  logic                 solver_done,
    output logic [NUM_NODES-1:0] fix_en,
    output logic                 anchor_sel,
    output logic                 busy,
    output logic                 frame_done,
    output logic [7:0]           overrun_cnt
);

    localparam int NUM_SEGS = NUM_NODES - 1;
    localparam int ITER_W   = idx_width(ITERATIONS);

    sched_state_e          r_state;
    sched_state_e          w_next;
    logic [IDX_W-1:0]      w_idx;
    logic [ITER_W-1:0]     w_iter;
    logic                  w_wrap_seg;
    logic                  w_last;
    logic [IDX_W-1:0]      r_sidx_hold;
    logic [7:0]            r_overrun;
    logic [NUM_NODES-1:0]  w_fix;

    seg_iter_counter #(
        .NUM_SEGS   (NUM_SEGS),
        .ITERATIONS (ITERATIONS),
        .IDX_W      (IDX_W),
        .ITER_W     (ITER_W)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (r_state == ST_IDLE),
        .i_step     (r_state == ST_WRITE),
        .o_idx      (w_idx),
        .o_iter     (w_iter),
        .o_wrap_seg (w_wrap_seg),
        .o_last     (w_last)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:       if (frame_tick) w_next = ST_VERLET;
            ST_VERLET:     w_next = ST_SOLVE_REQ;
            ST_SOLVE_REQ:  w_next = ST_SOLVE_WAIT;
            ST_SOLVE_WAIT: if (solver_done) w_next = ST_WRITE;
            ST_WRITE: begin
                if (w_wrap_seg && w_last) begin
`ifdef VERLET_SCHED_PIN_EN
                    w_next = ST_PIN;
`else
                    w_next = ST_DONE;
`endif
                end else begin
                    w_next = ST_SOLVE_REQ;
                end
            end
`ifdef VERLET_SCHED_PIN_EN
            ST_PIN:        w_next = ST_DONE;
`endif
            ST_DONE:       w_next = ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // solver_idx keeps the last requested segment between requests, even across IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sidx_hold <= '0;
        end else if (r_state == ST_SOLVE_REQ) begin
            r_sidx_hold <= w_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= '0;
        end else if (frame_tick && (r_state != ST_IDLE) && (r_overrun != 8'hFF)) begin
            r_overrun <= r_overrun + 8'd1;
        end
    end

    always_comb begin
        w_fix = '0;
        if (r_state == ST_WRITE) begin
            w_fix[w_idx]        = 1'b1;
            w_fix[w_idx + 1'b1] = 1'b1;
        end
`ifdef VERLET_SCHED_PIN_EN
        if (r_state == ST_PIN) begin
            w_fix[0] = 1'b1;
        end
`endif
    end

    assign verlet_state = (r_state == ST_VERLET);
    assign solver_start = (r_state == ST_SOLVE_REQ);
    assign solver_idx   = (r_state == ST_SOLVE_REQ) ? w_idx : r_sidx_hold;
    assign fix_en       = w_fix;
`ifdef VERLET_SCHED_PIN_EN
    assign anchor_sel   = (r_state == ST_PIN);
`else
    assign anchor_sel   = 1'b0;
`endif
    assign busy         = (r_state != ST_IDLE);
    assign frame_done   = (r_state == ST_DONE);
    assign overrun_cnt  = r_overrun;

endmodule

// File: tb/tb_verlet_scheduler.sv
// Self-checking bench for verlet_scheduler (NUM_NODES=4, ITERATIONS=2): frame table plus
// hand sequences for tick saturation and reset during SOLVE_WAIT.
module tb_verlet_scheduler;

    localparam int NN = 4;
    localparam int IT = 2;
    localparam int S  = NN - 1;
`ifdef VERLET_SCHED_PIN_EN
    localparam int PIN = 1;
`else
    localparam int PIN = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_tick;
    logic          solver_done;
    logic          verlet_state;
    logic          solver_start;
    logic [1:0]    solver_idx;
    logic [NN-1:0] fix_en;
    logic          anchor_sel;
    logic          busy;
    logic          frame_done;
    logic [7:0]    overrun_cnt;

    verlet_scheduler #(.NUM_NODES(NN), .ITERATIONS(IT)) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .verlet_state (verlet_state),
        .solver_start (solver_start),
        .solver_idx   (solver_idx),
        .solver_done  (solver_done),
        .fix_en       (fix_en),
        .anchor_sel   (anchor_sel),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w;
        int t0;
        int t1;
        int t2;
    } vec_t;

    typedef struct {
        int pat;
        int at;
    } fix_t;

    int   n_chk   = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   exp_ovr = 0;
    int   idx_q[$];
    fix_t fix_q[$];
    int   scnt    = 0;
    int   tied    = 0;
    int   sw      = 1;
    vec_t vecs[5];

    function automatic int frame_len(input int w);
        return 1 + IT * S * (2 + w) + 1 + PIN;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic solver_model();
        fix_t f;
        int   e;
        solver_done = (tied != 0);
        if (solver_start) begin
            if (idx_q.size() == 0) begin
                chk("unexpected_start", 32'd1, 32'd0);
            end else begin
                e = idx_q.pop_front();
                chk("solver_idx", 32'(solver_idx), e);
                f.pat = (1 << e) | (1 << (e + 1));
                f.at  = cyc + ((tied != 0) ? 1 : sw) + 1;
                fix_q.push_back(f);
                scnt = sw;
            end
        end else if (tied == 0 && scnt > 0) begin
            scnt--;
            if (scnt == 0) solver_done = 1'b1;
        end
    endtask

    task automatic chk_fix(input int pin_cyc);
        if (fix_q.size() > 0 && fix_q[0].at == cyc) begin
            chk("fix_en_seg", 32'(fix_en), fix_q[0].pat);
            void'(fix_q.pop_front());
        end
`ifdef VERLET_SCHED_PIN_EN
        else if (cyc == pin_cyc) begin
            chk("fix_en_pin", 32'(fix_en), 32'd1);
        end
`endif
        else begin
            chk("fix_en_quiet", 32'(fix_en), 32'd0);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int done_at;
        done_at = frame_len((v.w == 0) ? 1 : v.w);
        tied = (v.w == 0) ? 1 : 0;
        sw   = (v.w == 0) ? 1 : v.w;
        scnt = 0;
        chk("idle_busy", 32'(busy), 32'd0);
        for (int it = 0; it < IT; it++)
            for (int s = 0; s < S; s++)
                idx_q.push_back(s);
        cyc = 0;
        frame_tick = 1'b1;
        while (cyc <= done_at) begin
            step();
            frame_tick = 1'b0;
            solver_model();
            chk_fix(done_at - 1);
            chk("verlet_state", 32'(verlet_state), 32'(cyc == 1));
            chk("frame_done", 32'(frame_done), 32'(cyc == done_at));
            chk("busy", 32'(busy), 32'(cyc <= done_at));
`ifdef VERLET_SCHED_PIN_EN
            chk("anchor_sel", 32'(anchor_sel), 32'(cyc == done_at - 1));
`else
            chk("anchor_sel", 32'(anchor_sel), 32'd0);
`endif
            if (cyc == v.t0 || cyc == v.t1 || cyc == v.t2) begin
                frame_tick = 1'b1;
                exp_ovr = (exp_ovr < 255) ? exp_ovr + 1 : 255;
            end
        end
        solver_done = 1'b0;
        tied = 0;
        chk("overrun_cnt", 32'(overrun_cnt), exp_ovr);
        chk("idx_q_drained", idx_q.size(), 32'd0);
        chk("fix_q_drained", fix_q.size(), 32'd0);
        chk("solver_idx_hold", 32'(solver_idx), S - 1);
        idx_q.delete();
        fix_q.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_verlet_state"}, 32'(verlet_state), 32'd0);
        chk({tag, "_solver_start"}, 32'(solver_start), 32'd0);
        chk({tag, "_solver_idx"},   32'(solver_idx),   32'd0);
        chk({tag, "_fix_en"},       32'(fix_en),       32'd0);
        chk({tag, "_anchor_sel"},   32'(anchor_sel),   32'd0);
        chk({tag, "_busy"},         32'(busy),         32'd0);
        chk({tag, "_frame_done"},   32'(frame_done),   32'd0);
        chk({tag, "_overrun_cnt"},  32'(overrun_cnt),  32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        frame_tick  = 1'b0;
        solver_done = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;
        step();

        // w=0 means solver_done tied high (W=1); t = -1 means no extra tick
        vecs[0] = '{w: 0, t0: -1, t1: -1, t2: -1};
        vecs[1] = '{w: 5, t0: -1, t1: -1, t2: -1};
        vecs[2] = '{w: 2, t0: 3,  t1: 10, t2: 21};
        vecs[3] = '{w: 1, t0: frame_len(1), t1: -1, t2: -1};
        vecs[4] = '{w: 3, t0: 1,  t1: 2,  t2: -1};

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i]);
            step();
        end

        // Stall in SOLVE_WAIT while ticking far past the saturation point.
        cyc = 0;
        frame_tick = 1'b1;
        solver_done = 1'b0;
        step();
        chk("sat_verlet", 32'(verlet_state), 32'd1);
        for (int k = 0; k < 300; k++) step();
        frame_tick = 1'b0;
        exp_ovr = (exp_ovr + 300 > 255) ? 255 : exp_ovr + 300;
        chk("sat_overrun", 32'(overrun_cnt), exp_ovr);
        chk("sat_busy", 32'(busy), 32'd1);
        chk("sat_no_start", 32'(solver_start), 32'd0);

        // Reset while waiting; the result arriving next cycle must be discarded.
        reset = 1'b1;
        step();
        reset = 1'b0;
        solver_done = 1'b1;
        chk_reset_vals("rstwait");
        step();
        solver_done = 1'b0;
        chk("rstwait_fix_en_1", 32'(fix_en), 32'd0);
        chk("rstwait_busy_1", 32'(busy), 32'd0);
        step();
        chk("rstwait_fix_en_2", 32'(fix_en), 32'd0);
        chk("rstwait_overrun", 32'(overrun_cnt), 32'd0);
        exp_ovr = 0;

        run_frame(vecs[0]);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
